// File: rtl/reg_read_stage.sv
// reg_read_stage: operand-fetch stage in front of a two-port register file.
// It accepts decoded instructions and uses a per-register busy scoreboard to
// hold back read-after-write hazards. It issues synchronous reads on both
// register-file ports and funnels writeback writes through port A. Captured
// operands go to execute over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_*            decode side: valid/ready, source regs + use flags, rd, ctrl
//   out_*           execute side: valid/ready, operands, rd, write flag, ctrl
//   wb_*            writeback request (always accepted)
//   rf_*            register-file ports A (read/write) and B (read only)
module reg_read_stage #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned CTRL_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // decode side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs_a,
  input  logic [REG_ADDR_W-1:0] in_rs_b,
  input  logic                  in_use_a,
  input  logic                  in_use_b,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_rd,
  input  logic [CTRL_W-1:0]     in_ctrl,
  // execute side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  out_op_a,
  output logic [WORD_SIZE-1:0]  out_op_b,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_rd,
  output logic [CTRL_W-1:0]     out_ctrl,
  // writeback
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0]  wb_data,
  // register file
  output logic                  rf_wen_a,
  output logic                  rf_rd_a,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [WORD_SIZE-1:0]  rf_din_a,
  input  logic [WORD_SIZE-1:0]  rf_dout_a,
  output logic                  rf_wen_b,
  output logic                  rf_rd_b,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  output logic [WORD_SIZE-1:0]  rf_din_b,
  input  logic [WORD_SIZE-1:0]  rf_dout_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  use_a_q, use_a_d;
  logic                  use_b_q, use_b_d;
  logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic                  pend_wr_q, pend_wr_d;
  logic [CTRL_W-1:0]     pend_ctrl_q, pend_ctrl_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]  out_op_a_q, out_op_a_d;
  logic [WORD_SIZE-1:0]  out_op_b_q, out_op_b_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_wr_rd_q, out_wr_rd_d;
  logic [CTRL_W-1:0]     out_ctrl_q, out_ctrl_d;

  logic hazard_c;
  logic slot_free_c;
  logic accept_c;
  logic wb_en_c;

  // Handshake: a writeback owns port A, so it blocks any accept that cycle.
  always_comb begin
    hazard_c    = (in_use_a & busy_q[in_rs_a]) | (in_use_b & busy_q[in_rs_b]);
    slot_free_c = (state_q == S_IDLE) | ((state_q == S_FULL) & out_ready);
    in_ready    = ~rst & ~wb_valid & ~hazard_c & slot_free_c;
    accept_c    = in_valid & in_ready;
    wb_en_c     = wb_valid & ~rst;
  end

  // Register-file port drive; address/data are zeroed when a port is unused.
  always_comb begin
    rf_wen_a  = wb_en_c;
    rf_rd_a   = accept_c & in_use_a;
    rf_addr_a = '0;
    rf_din_a  = '0;
    rf_wen_b  = 1'b0;
    rf_rd_b   = accept_c & in_use_b;
    rf_addr_b = '0;
    rf_din_b  = '0;
    if (wb_en_c) begin
      rf_addr_a = wb_addr;
      rf_din_a  = wb_data;
    end else if (rf_rd_a) begin
      rf_addr_a = in_rs_a;
    end
    if (rf_rd_b) begin
      rf_addr_b = in_rs_b;
    end
  end

  // Next-state, scoreboard and output-register logic.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    use_a_d     = use_a_q;
    use_b_d     = use_b_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    pend_ctrl_d = pend_ctrl_q;
    out_valid_d = out_valid_q;
    out_op_a_d  = out_op_a_q;
    out_op_b_d  = out_op_b_q;
    out_rd_d    = out_rd_q;
    out_wr_rd_d = out_wr_rd_q;
    out_ctrl_d  = out_ctrl_q;

    // busy is set after the hazard check, so rd==rs still reads the old value
    if (accept_c) begin
      use_a_d     = in_use_a;
      use_b_d     = in_use_b;
      pend_rd_d   = in_rd;
      pend_wr_d   = in_wr_rd;
      pend_ctrl_d = in_ctrl;
      if (in_wr_rd) begin
        busy_d[in_rd] = 1'b1;
      end
    end
    if (wb_en_c) begin
      busy_d[wb_addr] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_READ;
        end
      end
      // rf_dout_* were registered at the issue edge; unused sources read as 0
      S_READ: begin
        state_d     = S_FULL;
        out_valid_d = 1'b1;
        out_op_a_d  = use_a_q ? rf_dout_a : '0;
        out_op_b_d  = use_b_q ? rf_dout_b : '0;
        out_rd_d    = pend_rd_q;
        out_wr_rd_d = pend_wr_q;
        out_ctrl_d  = pend_ctrl_q;
      end
      S_FULL: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept_c ? S_READ : S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      use_a_q     <= 1'b0;
      use_b_q     <= 1'b0;
      pend_rd_q   <= '0;
      pend_wr_q   <= 1'b0;
      pend_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
      out_rd_q    <= '0;
      out_wr_rd_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      use_a_q     <= use_a_d;
      use_b_q     <= use_b_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      pend_ctrl_q <= pend_ctrl_d;
      out_valid_q <= out_valid_d;
      out_op_a_q  <= out_op_a_d;
      out_op_b_q  <= out_op_b_d;
      out_rd_q    <= out_rd_d;
      out_wr_rd_q <= out_wr_rd_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = out_op_a_q;
  assign out_op_b  = out_op_b_q;
  assign out_rd    = out_rd_q;
  assign out_wr_rd = out_wr_rd_q;
  assign out_ctrl  = out_ctrl_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: directed and randomized bench for reg_read_stage.
// Includes a behavioural register file attached to the rf_* ports and a
// reference model that tracks architectural register values, pending writers
// and the age of the instruction in flight.
module tb_reg_read_stage;
  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CTRL_W     = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready;
  logic [REG_ADDR_W-1:0] in_rs_a, in_rs_b, in_rd;
  logic                  in_use_a, in_use_b, in_wr_rd;
  logic [CTRL_W-1:0]     in_ctrl;
  logic                  out_valid, out_ready;
  logic [WORD_SIZE-1:0]  out_op_a, out_op_b;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wr_rd;
  logic [CTRL_W-1:0]     out_ctrl;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [WORD_SIZE-1:0]  wb_data;
  logic                  rf_wen_a, rf_rd_a, rf_wen_b, rf_rd_b;
  logic [REG_ADDR_W-1:0] rf_addr_a, rf_addr_b;
  logic [WORD_SIZE-1:0]  rf_din_a, rf_din_b, rf_dout_a, rf_dout_b;

  always #5 clk = ~clk;

  reg_read_stage #(
    .WORD_SIZE (WORD_SIZE),
    .REG_ADDR_W(REG_ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .CTRL_W    (CTRL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_use_a(in_use_a), .in_use_b(in_use_b),
    .in_rd(in_rd), .in_wr_rd(in_wr_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_wr_rd(out_wr_rd), .out_ctrl(out_ctrl),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_wen_a(rf_wen_a), .rf_rd_a(rf_rd_a), .rf_addr_a(rf_addr_a),
    .rf_din_a(rf_din_a), .rf_dout_a(rf_dout_a),
    .rf_wen_b(rf_wen_b), .rf_rd_b(rf_rd_b), .rf_addr_b(rf_addr_b),
    .rf_din_b(rf_din_b), .rf_dout_b(rf_dout_b)
  );

  // Behavioural two-port register file with registered read data.
  logic                 rf_clr;
  logic [WORD_SIZE-1:0] rf_mem [NUM_REGS];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_mem[i] <= '0;
    end else begin
      if (rf_wen_a) rf_mem[rf_addr_a] <= rf_din_a;
      if (rf_wen_b) rf_mem[rf_addr_b] <= rf_din_b;
    end
    if (rf_rd_a) rf_dout_a <= rf_mem[rf_addr_a];
    if (rf_rd_b) rf_dout_b <= rf_mem[rf_addr_b];
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [WORD_SIZE-1:0]  m_regs [NUM_REGS];
  bit                    m_busy [NUM_REGS];
  bit                    m_inflight;
  int                    m_age;
  logic [WORD_SIZE-1:0]  m_snap_a, m_snap_b;
  logic [REG_ADDR_W-1:0] m_snap_rd;
  logic                  m_snap_wr;
  logic [CTRL_W-1:0]     m_snap_ctrl;
  logic [WORD_SIZE-1:0]  m_out_a, m_out_b;
  logic [REG_ADDR_W-1:0] m_out_rd;
  logic                  m_out_wr;
  logic [CTRL_W-1:0]     m_out_ctrl;
  bit                    exp_ready, exp_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_outputs();
    m_inflight = 1'b0;
    m_age      = 0;
    m_out_a    = '0;
    m_out_b    = '0;
    m_out_rd   = '0;
    m_out_wr   = 1'b0;
    m_out_ctrl = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) m_busy[i] = 1'b0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model
  // at the edge, then check the registered outputs.
  task automatic tick();
    bit hz, slot, wbe;
    logic [REG_ADDR_W-1:0] ea;
    #3;
    hz   = (in_use_a && m_busy[in_rs_a]) || (in_use_b && m_busy[in_rs_b]);
    slot = !m_inflight || (m_age >= 2 && out_ready);
    exp_ready = !rst && !wb_valid && !hz && slot;
    exp_acc   = exp_ready && in_valid;
    wbe       = wb_valid && !rst;
    ea        = wbe ? wb_addr : ((exp_acc && in_use_a) ? in_rs_a : '0);
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("rf_wen_a",  64'(rf_wen_a),  64'(wbe));
    chk("rf_rd_a",   64'(rf_rd_a),   64'(exp_acc && in_use_a));
    chk("rf_addr_a", 64'(rf_addr_a), 64'(ea));
    chk("rf_din_a",  64'(rf_din_a),  64'(wbe ? wb_data : '0));
    chk("rf_rd_b",   64'(rf_rd_b),   64'(exp_acc && in_use_b));
    chk("rf_addr_b", 64'(rf_addr_b), 64'((exp_acc && in_use_b) ? in_rs_b : '0));
    chk("rf_wen_b",  64'(rf_wen_b),  64'(0));
    chk("rf_din_b",  64'(rf_din_b),  64'(0));
    @(posedge clk);
    #1;
    if (rst) begin
      clear_outputs();
    end else begin
      if (m_inflight && m_age >= 2 && out_ready) begin
        m_inflight = 1'b0;
      end else if (m_inflight) begin
        m_age++;
        if (m_age == 2) begin
          m_out_a    = m_snap_a;
          m_out_b    = m_snap_b;
          m_out_rd   = m_snap_rd;
          m_out_wr   = m_snap_wr;
          m_out_ctrl = m_snap_ctrl;
        end
      end
      if (exp_acc) begin
        m_snap_a    = in_use_a ? m_regs[in_rs_a] : '0;
        m_snap_b    = in_use_b ? m_regs[in_rs_b] : '0;
        m_snap_rd   = in_rd;
        m_snap_wr   = in_wr_rd;
        m_snap_ctrl = in_ctrl;
        m_inflight  = 1'b1;
        m_age       = 1;
        if (in_wr_rd) m_busy[in_rd] = 1'b1;
      end
      if (wb_valid) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
    end
    chk("out_valid", 64'(out_valid), 64'(m_inflight && m_age >= 2));
    chk("out_op_a",  64'(out_op_a),  64'(m_out_a));
    chk("out_op_b",  64'(out_op_b),  64'(m_out_b));
    chk("out_rd",    64'(out_rd),    64'(m_out_rd));
    chk("out_wr_rd", 64'(out_wr_rd), 64'(m_out_wr));
    chk("out_ctrl",  64'(out_ctrl),  64'(m_out_ctrl));
  endtask

  task automatic quiet();
    in_valid  = 1'b0;
    in_rs_a   = '0;
    in_rs_b   = '0;
    in_use_a  = 1'b0;
    in_use_b  = 1'b0;
    in_rd     = '0;
    in_wr_rd  = 1'b0;
    in_ctrl   = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  task automatic set_instr(input logic [REG_ADDR_W-1:0] ra, input logic [REG_ADDR_W-1:0] rb,
                           input bit ua, input bit ub, input logic [REG_ADDR_W-1:0] rd,
                           input bit wr, input logic [CTRL_W-1:0] ctrl);
    in_valid = 1'b1;
    in_rs_a  = ra;
    in_rs_b  = rb;
    in_use_a = ua;
    in_use_b = ub;
    in_rd    = rd;
    in_wr_rd = wr;
    in_ctrl  = ctrl;
  endtask

  task automatic set_wb(input bit v, input logic [REG_ADDR_W-1:0] a, input logic [WORD_SIZE-1:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    quiet();
    rst    = 1'b1;
    rf_clr = 1'b1;
    for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = '0;
    clear_outputs();
    set_instr(1, 2, 1, 1, 3, 1, 16'h1234);
    set_wb(1, 6, 32'hABCD0000);
    tick();
    tick();
    rf_clr = 1'b0;
    rst    = 1'b0;
    quiet();
    tick();

    // Basic read of two freshly written registers, two-cycle latency.
    set_wb(1, 3, 32'h11111111); tick();
    set_wb(1, 4, 32'h22222222); tick();
    set_wb(0, 0, '0);
    set_instr(3, 4, 1, 1, 0, 0, 16'hA001);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_valid_latency", 64'(out_valid), 64'(1));
    chk("t1_op_a", 64'(out_op_a), 64'(32'h11111111));
    chk("t1_op_b", 64'(out_op_b), 64'(32'h22222222));
    tick();

    // RAW stall on r5 until its writeback lands.
    set_instr(0, 0, 0, 0, 5, 1, 16'hA002);
    tick();
    set_instr(5, 0, 1, 0, 6, 0, 16'hA003);
    #1 chk("t2_stalled", 64'(in_ready), 64'(0));
    for (int i = 0; i < 3; i++) tick();
    set_wb(1, 5, 32'hDEADBEEF);
    tick();
    set_wb(0, 0, '0);
    #1 chk("t2_ready_after_wb", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_op_a", 64'(out_op_a), 64'(32'hDEADBEEF));
    tick();

    // Writebacks held for 4 cycles block accepts.
    set_instr(1, 2, 1, 1, 0, 0, 16'hA004);
    for (int i = 0; i < 4; i++) begin
      set_wb(1, REG_ADDR_W'(10 + i), $urandom());
      #1 chk("t3_wen", 64'(rf_wen_a), 64'(1));
      chk("t3_no_rd", 64'({rf_rd_a, rf_rd_b}), 64'(0));
      tick();
    end
    quiet();
    tick();
    tick();

    // Back-pressure in FULL, then handoff and accept in one cycle.
    out_ready = 1'b0;
    set_instr(3, 4, 1, 1, 8, 0, 16'hA005);
    tick();
    in_valid = 1'b0;
    tick();
    set_instr(4, 3, 1, 1, 11, 0, 16'hA006);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_held_ready", 64'(in_ready), 64'(0));
      tick();
      chk("t4_held_op_a", 64'(out_op_a), 64'(32'h11111111));
    end
    out_ready = 1'b1;
    #1 chk("t4_handoff_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4_next_op_a", 64'(out_op_a), 64'(32'h22222222));
    tick();

    // Unused source with a busy register does not stall.
    set_instr(0, 0, 0, 0, 9, 1, 16'hA007);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    set_instr(9, 3, 0, 1, 12, 0, 16'hA008);
    #1 chk("t5_no_stall", 64'(in_ready), 64'(1));
    chk("t5_rd_a", 64'(rf_rd_a), 64'(0));
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_op_a", 64'(out_op_a), 64'(0));
    chk("t5_op_b", 64'(out_op_b), 64'(32'h11111111));
    tick();

    // Reset during READ discards the instruction and clears the scoreboard.
    set_wb(1, 7, 32'h77777777);
    tick();
    set_wb(0, 0, '0);
    set_instr(0, 0, 0, 0, 7, 1, 16'hA009);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("t6_valid_after_rst", 64'(out_valid), 64'(0));
    rst = 1'b0;
    set_instr(7, 9, 1, 1, 0, 0, 16'hA00A);
    #1 chk("t6_ready_r7", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_op_a", 64'(out_op_a), 64'(32'h77777777));
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs_a   = REG_ADDR_W'($urandom_range(0, 7));
      in_rs_b   = REG_ADDR_W'($urandom_range(0, 7));
      in_use_a  = $urandom_range(0, 1) == 1;
      in_use_b  = $urandom_range(0, 1) == 1;
      in_rd     = REG_ADDR_W'($urandom_range(0, 7));
      in_wr_rd  = $urandom_range(0, 1) == 1;
      in_ctrl   = CTRL_W'($urandom());
      wb_valid  = ($urandom_range(0, 3) == 0);
      wb_addr   = REG_ADDR_W'($urandom_range(0, 7));
      wb_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    quiet();
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
